pid_capture: RTL

Upstream stage of the PID FIFO in the USB receive path. It watches the decoded receive byte stream, captures and validates the PID byte of each packet, and checks packet length against the PID class. On a clean end-of-packet it pushes exactly one PID byte into the PID FIFO, so the FIFO records the order in which valid packets arrived. Malformed, aborted or erroneous packets never reach the FIFO and are reported on error pulses.

---
 rtl/usb_pkg.sv | 40 ++++
 rtl/pid_capture.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/usb_pkg.sv
// Shared USB receive-path definitions: PID codes, PID classes and packet length limits.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam int unsigned TOKEN_LEN     = 3;
  localparam int unsigned HS_LEN        = 1;
  localparam int unsigned DATA_OVERHEAD = 3;

  typedef enum logic [1:0] {
    TOKEN,
    DATA,
    HANDSHAKE,
    INVALID
  } pid_class_t;

  // A PID byte is only meaningful when its upper nibble is the complement of the lower one.
  function automatic pid_class_t pid_classify(input logic [7:0] b);
    pid_class_t c;
    c = INVALID;
    if (b[7:4] == ~b[3:0]) begin
      case (b[3:0])
        PID_OUT, PID_IN, PID_SOF, PID_SETUP: c = TOKEN;
        PID_DATA0, PID_DATA1:                c = DATA;
        PID_ACK, PID_NAK, PID_STALL:         c = HANDSHAKE;
        default:                             c = INVALID;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/pid_capture.sv
// Captures and validates the PID of each received USB packet, checks its length
// against the PID class and pushes one PID byte into the PID FIFO per clean packet.
module pid_capture
  import usb_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       packet_start,
  input  logic       byte_valid,
  input  logic [7:0] rx_byte,
  input  logic       eop,
  input  logic       rx_err,
  input  logic       fifo_full,
  output logic       fifo_w_enable,
  output logic [7:0] fifo_w_data,
  output logic       pid_err,
  output logic       len_err,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_PID,
    S_BODY,
    S_COMMIT,
    S_DISCARD
  } state_t;

  localparam logic [CNT_W-1:0] TOK_N  = CNT_W'(TOKEN_LEN);
  localparam logic [CNT_W-1:0] HS_N   = CNT_W'(HS_LEN);
  localparam logic [CNT_W-1:0] DMIN_N = CNT_W'(DATA_OVERHEAD);
  localparam logic [CNT_W-1:0] DMAX_N = CNT_W'(MAX_PAYLOAD + DATA_OVERHEAD);

  function automatic logic len_ok(input pid_class_t c, input logic [CNT_W-1:0] n);
    logic ok;
    ok = 1'b0;
    case (c)
      TOKEN:     ok = (n == TOK_N);
      DATA:      ok = (n >= DMIN_N) && (n <= DMAX_N);
      HANDSHAKE: ok = (n == HS_N);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       pid_q, pid_d;
  logic             fifo_w_enable_q, fifo_w_enable_d;
  logic [7:0]       fifo_w_data_q, fifo_w_data_d;
  logic             pid_err_q, pid_err_d;
  logic             len_err_q, len_err_d;
  logic             overflow_q, overflow_d;

  logic             eval;
  pid_class_t       ev_cls;
  logic [CNT_W-1:0] ev_cnt;
  logic [7:0]       ev_pid;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pid_d           = pid_q;
    fifo_w_enable_d = 1'b0;
    fifo_w_data_d   = fifo_w_data_q;
    pid_err_d       = 1'b0;
    len_err_d       = 1'b0;
    overflow_d      = 1'b0;
    eval            = 1'b0;
    ev_cls          = INVALID;
    ev_cnt          = cnt_q;
    ev_pid          = pid_q;
    cnt_inc         = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (packet_start) begin
          state_d = S_GET_PID;
          cnt_d   = '0;
        end
      end
      S_GET_PID: begin
        if (rx_err) begin
          state_d = S_DISCARD;
        end else if (byte_valid) begin
          pid_d = rx_byte;
          cnt_d = CNT_W'(1);
          if (pid_classify(rx_byte) == INVALID) begin
            pid_err_d = 1'b1;
            state_d   = eop ? S_IDLE : S_DISCARD;
          end else if (eop) begin
            eval   = 1'b1;
            ev_cls = pid_classify(rx_byte);
            ev_cnt = CNT_W'(1);
            ev_pid = rx_byte;
          end else begin
            state_d = S_BODY;
          end
        end else if (eop) begin
          state_d = S_IDLE;
        end
      end
      S_BODY: begin
        // A byte arriving with eop is counted before the length is judged.
        ev_cnt = byte_valid ? cnt_inc : cnt_q;
        cnt_d  = ev_cnt;
        ev_cls = pid_classify(pid_q);
        if (eop && !rx_err) begin
          eval = 1'b1;
        end else if (rx_err) begin
          state_d = S_DISCARD;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_DISCARD: begin
        if (eop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The FIFO decision is registered on entry to COMMIT so the write strobe is flop-driven.
    if (eval) begin
      if (!len_ok(ev_cls, ev_cnt)) begin
        len_err_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        state_d         = S_COMMIT;
        fifo_w_enable_d = !fifo_full;
        overflow_d      = fifo_full;
        if (!fifo_full) fifo_w_data_d = ev_pid;
      end
    end

    if (packet_start && state_q != S_IDLE) begin
      state_d         = S_GET_PID;
      cnt_d           = '0;
      fifo_w_enable_d = 1'b0;
      fifo_w_data_d   = fifo_w_data_q;
      pid_err_d       = 1'b0;
      overflow_d      = 1'b0;
      len_err_d       = (state_q == S_BODY);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      pid_q           <= '0;
      fifo_w_enable_q <= 1'b0;
      fifo_w_data_q   <= '0;
      pid_err_q       <= 1'b0;
      len_err_q       <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pid_q           <= pid_d;
      fifo_w_enable_q <= fifo_w_enable_d;
      fifo_w_data_q   <= fifo_w_data_d;
      pid_err_q       <= pid_err_d;
      len_err_q       <= len_err_d;
      overflow_q      <= overflow_d;
    end
  end

  assign fifo_w_enable = fifo_w_enable_q;
  assign fifo_w_data   = fifo_w_data_q;
  assign pid_err       = pid_err_q;
  assign len_err       = len_err_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != S_IDLE);

endmodule
